// File: rtl/oversample_cdr.sv
// Clock/data recovery stage behind the 8x input oversampler.
// Each clock brings one 8-sample word. The block tracks the phase of the
// data edges with a small up/down filter and takes the sample nearest the
// eye centre. When the sample point wraps across a word boundary it emits
// 0 or 2 bits instead of 1, which absorbs a small frequency offset.
module oversample_cdr #(
    parameter logic [7:0] INV_MASK   = 8'hAA,
    parameter int         FILT_LIMIT = 8,
    parameter int         LOCK_EDGES = 64
) (
    input  logic       c,
    input  logic       r,
    input  logic [7:0] i,
    output logic [1:0] d,
    output logic [1:0] n,
    output logic       locked
);

    // Filter limits as 9-bit two's complement so accSum compares directly
    localparam logic [8:0]  ACC_POS  = 9'(FILT_LIMIT);
    localparam logic [8:0]  ACC_NEG  = 9'(-FILT_LIMIT);
    localparam logic [15:0] LOCK_MAX = 16'(LOCK_EDGES);

    logic [7:0]  word_q;
    logic        prev_q;
    logic [2:0]  ph_q, ph_d;
    logic [2:0]  phLast_q;
    logic [7:0]  acc_q, acc_d;
    logic [15:0] lockCnt_q, lockCnt_d;
    logic [1:0]  dOut_q, dOut_d;
    logic [1:0]  nOut_q, nOut_d;
    logic        locked_q;

    logic [7:0]  x;
    logic [7:0]  edges;
    logic [2:0]  t0;
    logic [2:0]  err;
    logic [2:0]  sp;
    logic [2:0]  spLast;
    logic        edgeFound;
    logic        glitch;
    logic        stepUp;
    logic        stepDn;
    logic        goodEdge;
    logic        badEdge;
    logic        lateSlip;
    logic        earlySlip;
    logic [8:0]  accSum;

    // Input register: undo odd-bit inversion and remember the last sample of the previous word
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            word_q <= '0;
            prev_q <= 1'b0;
        end else begin
            word_q <= i ^ INV_MASK;
            prev_q <= word_q[0];
        end
    end

    // Reorder the word so x[0] is the earliest sample
    always_comb begin
        x = '0;
        for (int t = 0; t < 8; t++) begin
            x[t] = word_q[7 - t];
        end
    end

    assign edges = x ^ {x[6:0], prev_q};

    // Earliest edge wins; any further edge in the same word marks it as a glitch
    always_comb begin
        t0 = 3'd0;
        for (int t = 7; t >= 0; t--) begin
            if (edges[t]) begin
                t0 = 3'(t);
            end
        end
    end

    assign edgeFound = |edges;
    assign glitch    = |(edges & (edges - 8'd1));
    assign err       = t0 - ph_q;

    // err of exactly -4 (3'b100) is ambiguous in direction and gives no step
    assign stepUp   = edgeFound && (err inside {3'd1, 3'd2, 3'd3});
    assign stepDn   = edgeFound && (err inside {3'd5, 3'd6, 3'd7});
    assign goodEdge = edgeFound && !glitch && (err inside {3'd0, 3'd1, 3'd7});
    assign badEdge  = edgeFound && (glitch || (err inside {3'd3, 3'd4, 3'd5}));

    assign accSum = {acc_q[7], acc_q} + (stepUp ? 9'd1 : (stepDn ? 9'h1FF : 9'd0));

    // Phase filter: a full accumulator moves the tracked phase by one sample
    always_comb begin
        ph_d  = ph_q;
        acc_d = accSum[7:0];
        if (accSum == ACC_POS) begin
            ph_d  = ph_q + 3'd1;
            acc_d = '0;
        end else if (accSum == ACC_NEG) begin
            ph_d  = ph_q - 3'd1;
            acc_d = '0;
        end
    end

    // Lock counter: good edges count up to saturation, bad edges restart it
    always_comb begin
        lockCnt_d = lockCnt_q;
        if (badEdge) begin
            lockCnt_d = '0;
        end else if (goodEdge && (lockCnt_q != LOCK_MAX)) begin
            lockCnt_d = lockCnt_q + 16'd1;
        end
    end

    // Sample point sits half a UI away from the edge; compare with last word to spot wraps
    assign sp        = ph_q + 3'd4;
    assign spLast    = phLast_q + 3'd4;
    assign lateSlip  = (spLast == 3'd7) && (sp == 3'd0);
    assign earlySlip = (spLast == 3'd0) && (sp == 3'd7);

    // Output selection: late wrap re-reads a taken bit, early wrap must catch up by one
    always_comb begin
        nOut_d = 2'd1;
        dOut_d = {1'b0, x[sp]};
        if (lateSlip) begin
            nOut_d = 2'd0;
            dOut_d = dOut_q;
        end else if (earlySlip) begin
            nOut_d = 2'd2;
            dOut_d = {prev_q, x[7]};
        end
    end

    // Tracking state: phase, filter accumulator, lock counter and lock flag
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            ph_q      <= '0;
            phLast_q  <= '0;
            acc_q     <= '0;
            lockCnt_q <= '0;
            locked_q  <= 1'b0;
        end else begin
            ph_q      <= ph_d;
            phLast_q  <= ph_q;
            acc_q     <= acc_d;
            lockCnt_q <= lockCnt_d;
            locked_q  <= (lockCnt_d == LOCK_MAX);
        end
    end

    // Output register
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            dOut_q <= '0;
            nOut_q <= '0;
        end else begin
            dOut_q <= dOut_d;
            nOut_q <= nOut_d;
        end
    end

    assign d      = dOut_q;
    assign n      = nOut_q;
    assign locked = locked_q;

endmodule

// File: tb/tb_oversample_cdr.sv
// Directed bench for oversample_cdr: reset, acquisition and lock, late and
// early sample-point wraps, a glitch word while locked, and reset mid-stream.
`timescale 1ns/1ps
module tb_oversample_cdr;

    logic       c = 1'b0;
    logic       r;
    logic [7:0] i;
    logic [1:0] d;
    logic [1:0] n;
    logic       locked;

    int   checksRun    = 0;
    int   checksPassed = 0;

    logic       lastBit;
    logic       pendValid;
    logic [1:0] pendN;
    logic [1:0] pendD;

    oversample_cdr dut (
        .c     (c),
        .r     (r),
        .i     (i),
        .d     (d),
        .n     (n),
        .locked(locked)
    );

    // 400 MHz sample clock, scaled
    always #5 c = ~c;

    // Build an oversampler word: samples before t carry p, from t on carry b
    function automatic logic [7:0] mkWord(input logic p, input logic b, input int t);
        logic [7:0] s;
        s = '0;
        for (int j = 0; j < 8; j++) begin
            s[7 - j] = (j < t) ? p : b;
        end
        return s ^ 8'hAA;
    endfunction

    // Glitch word: edges at t=1 and t=3, level back to p afterwards
    function automatic logic [7:0] mkGlitch(input logic p);
        logic [7:0] s;
        s = {p, ~p, ~p, p, p, p, p, p};
        return s ^ 8'hAA;
    endfunction

    task automatic checkOutput(input string tag, input logic [1:0] obs, input logic [1:0] expv);
        checksRun++;
        if (obs === expv) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drive one word, clock it in and sample just after the edge
    task automatic applyStimulus(input logic [7:0] w);
        i = w;
        @(posedge c);
        #1;
    endtask

    // Outputs lag the word by one applyStimulus call, so expectations are held one word
    task automatic sendWord(input logic [7:0] w, input logic [1:0] eN, input logic [1:0] eD,
                            input string tag);
        applyStimulus(w);
        if (pendValid) begin
            checkOutput({tag, "_n"}, n, pendN);
            checkOutput({tag, "_d"}, d, pendD);
        end
        pendN     = eN;
        pendD     = eD;
        pendValid = 1'b1;
    endtask

    // Alternating data with edges at t=2, starting from all-zero history
    task automatic runAcquire(input string tag);
        logic b;
        for (int k = 0; k < 80; k++) begin
            b = (k % 2 == 0);
            sendWord(mkWord(lastBit, b, 2), 2'd1, {1'b0, b}, tag);
            lastBit = b;
            if (k == 0)  checkOutput({tag, "_lock_start"}, {1'b0, locked}, 2'd0);
            if (k == 71) checkOutput({tag, "_lock_63"},    {1'b0, locked}, 2'd0);
            if (k == 72) checkOutput({tag, "_lock_64"},    {1'b0, locked}, 2'd1);
        end
    endtask

    initial begin
        logic       b;
        logic       p;
        logic [1:0] eN;
        logic [1:0] eD;
        logic [1:0] heldD;

        r         = 1'b1;
        i         = 8'h5A;
        pendValid = 1'b0;
        lastBit   = 1'b0;
        heldD     = 2'd0;

        // Reset held while the input toggles
        for (int k = 0; k < 3; k++) begin
            i = ~i;
            @(posedge c);
            #1;
            checkOutput("rst_d", d, 2'd0);
            checkOutput("rst_n", n, 2'd0);
            checkOutput("rst_locked", {1'b0, locked}, 2'd0);
        end
        r = 1'b0;

        // Constant zero data: one zero bit per clock
        for (int k = 0; k < 6; k++) begin
            sendWord(8'hAA, 2'd1, 2'd0, "idle");
        end

        // Acquisition: ph walks 0 -> 1 -> 2, lock after 64 good edges
        runAcquire("acq");

        // Late drift: edges move to t=4, ph 2 -> 3 -> 4, sp wraps 7 -> 0
        for (int k = 0; k < 24; k++) begin
            b = ~lastBit;
            if (k <= 15) begin
                eN = 2'd1;
                eD = {1'b0, b};
            end else if (k == 16) begin
                eN = 2'd0;
                eD = heldD;
            end else begin
                eN = 2'd1;
                eD = {1'b0, lastBit};
            end
            sendWord(mkWord(lastBit, b, 4), eN, eD, "late");
            heldD   = eD;
            lastBit = b;
        end

        // Early drift: edges move to t=3, ph 4 -> 3, sp wraps 0 -> 7
        for (int k = 0; k < 16; k++) begin
            b = ~lastBit;
            if (k <= 7) begin
                eN = 2'd1;
                eD = {1'b0, lastBit};
            end else if (k == 8) begin
                eN = 2'd2;
                eD = {lastBit, b};
            end else begin
                eN = 2'd1;
                eD = {1'b0, b};
            end
            sendWord(mkWord(lastBit, b, 3), eN, eD, "early");
            lastBit = b;
        end

        // Steady at ph=3 long enough to be locked whatever happened above
        for (int k = 0; k < 70; k++) begin
            b = ~lastBit;
            sendWord(mkWord(lastBit, b, 3), 2'd1, {1'b0, b}, "hold");
            lastBit = b;
        end
        checkOutput("hold_locked", {1'b0, locked}, 2'd1);

        // Glitch word while locked: bit still recovered, lock drops
        p = lastBit;
        sendWord(mkGlitch(p), 2'd1, {1'b0, p}, "glitch");
        checkOutput("glitch_locked_before", {1'b0, locked}, 2'd1);
        for (int k = 0; k < 70; k++) begin
            b = ~lastBit;
            sendWord(mkWord(lastBit, b, 3), 2'd1, {1'b0, b}, "relock");
            lastBit = b;
            if (k == 0) checkOutput("glitch_locked_after", {1'b0, locked}, 2'd0);
            if (k == 3) checkOutput("glitch_locked_still", {1'b0, locked}, 2'd0);
        end
        checkOutput("relock_locked", {1'b0, locked}, 2'd1);

        // Reset mid-stream: outputs clear without waiting for a clock
        #2;
        r = 1'b1;
        #1;
        checkOutput("midrst_d", d, 2'd0);
        checkOutput("midrst_n", n, 2'd0);
        checkOutput("midrst_locked", {1'b0, locked}, 2'd0);
        i = 8'hAA;
        @(posedge c);
        #1;
        r         = 1'b0;
        pendValid = 1'b0;
        lastBit   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sendWord(8'hAA, 2'd1, 2'd0, "idle2");
        end
        runAcquire("reacq");

        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end

endmodule
